spi_rf_bridge: RTL and testbench

//  SPI target that turns an external SPI host's serial frames into regfile memory-interface transactions.

---
 rtl/spi_rf_bridge.sv | 211 +++++++++++++++++++++
 tb/tb_spi_rf_bridge.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_rf_bridge.sv
// SPI mode-0 target that turns host frames into byte-granular regfile reads and writes.
// SPI pins are oversampled on clk_i; byte addresses auto-increment and wrap within the regfile.
`timescale 1ns/1ps
module spi_rf_bridge #(
  parameter int AWIDTH      = 5,
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 spi_sclk_i,
  input  logic                 spi_cs_n_i,
  input  logic                 spi_mosi_i,
  output logic                 spi_miso_o,
  output logic                 spi_miso_oe_o,
  output logic [AWIDTH-1:0]    addr_o,
  output logic                 we_o,
  output logic [WIDTH-1:0]     wdata_o,
  output logic [WIDTH/8-1:0]   wmask_o,
  input  logic [WIDTH-1:0]     rdata_i,
  output logic                 frame_active_o
);

  localparam int NB  = WIDTH / 8;
  localparam int LB  = $clog2(NB);
  localparam int BAW = AWIDTH + LB;
  localparam logic [BAW-1:0] LANE_MASK = BAW'(NB - 1);

  typedef enum logic [1:0] {IDLE, CMD, WDATA, RDATA} state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] sclkSync_q, csSync_q, mosiSync_q;
  logic                   sclkPrev_q, csPrev_q;
  logic                   sclkS, csS, mosiS;
  logic                   sclkRise, sclkFall, csFall, csRise, riseEn, byteDone;

  logic [7:0]        rxShift_q, rxShift_d, rxByte;
  logic [2:0]        bitCnt_q, bitCnt_d;
  logic [BAW-1:0]    byteAddr_q, byteAddr_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [WIDTH-1:0]  wdata_q, wdata_d;
  logic [NB-1:0]     wmask_q, wmask_d;
  logic [7:0]        txShift_q, txShift_d;
  logic              loadPend_q, loadPend_d;
  logic              skipFall_q, skipFall_d;

  function automatic logic [AWIDTH-1:0] rowOf(input logic [BAW-1:0] a);
    logic [BAW-1:0] t;
    t = a >> LB;
    return t[AWIDTH-1:0];
  endfunction

  function automatic logic [NB-1:0] laneMaskOf(input logic [BAW-1:0] a);
    logic [NB-1:0] m;
    m = '0;
    for (int i = 0; i < NB; i++) m[i] = ((a & LANE_MASK) == BAW'(i));
    return m;
  endfunction

  function automatic logic [7:0] laneByteOf(input logic [BAW-1:0] a, input logic [WIDTH-1:0] d);
    logic [7:0] b;
    b = 8'h00;
    for (int i = 0; i < NB; i++) if ((a & LANE_MASK) == BAW'(i)) b = d[8*i +: 8];
    return b;
  endfunction

  // Synchronizers idle at the inactive pin levels so reset never looks like a CS fall.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sclkSync_q <= '0;
      csSync_q   <= '1;
      mosiSync_q <= '0;
      sclkPrev_q <= 1'b0;
      csPrev_q   <= 1'b1;
    end else begin
      sclkSync_q <= {sclkSync_q[SYNC_STAGES-2:0], spi_sclk_i};
      csSync_q   <= {csSync_q[SYNC_STAGES-2:0], spi_cs_n_i};
      mosiSync_q <= {mosiSync_q[SYNC_STAGES-2:0], spi_mosi_i};
      sclkPrev_q <= sclkS;
      csPrev_q   <= csS;
    end
  end

  assign sclkS    = sclkSync_q[SYNC_STAGES-1];
  assign csS      = csSync_q[SYNC_STAGES-1];
  assign mosiS    = mosiSync_q[SYNC_STAGES-1];
  assign sclkRise = sclkS & ~sclkPrev_q;
  assign sclkFall = ~sclkS & sclkPrev_q;
  assign csFall   = ~csS & csPrev_q;
  assign csRise   = csS & ~csPrev_q;
  // Gating on the previous CS sample lets a rise coincident with CS release still finish its byte.
  assign riseEn   = sclkRise & ~csPrev_q & (state_q != IDLE);
  assign byteDone = riseEn & (bitCnt_q == 3'd7);
  assign rxByte   = {rxShift_q[6:0], mosiS};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (csFall) state_d = CMD;
      CMD: begin
        if (csRise)        state_d = IDLE;
        else if (byteDone) state_d = rxByte[7] ? WDATA : RDATA;
      end
      default: if (csRise) state_d = IDLE;
    endcase
  end

  always_comb begin
    spi_miso_o = 1'b0;
    if (state_q == RDATA) spi_miso_o = txShift_q[7];
  end

  assign spi_miso_oe_o  = ~csS;
  assign frame_active_o = ~csS;

  always_comb begin
    rxShift_d  = rxShift_q;
    bitCnt_d   = bitCnt_q;
    byteAddr_d = byteAddr_q;
    addr_d     = addr_q;
    we_d       = 1'b0;
    wdata_d    = wdata_q;
    wmask_d    = '0;
    txShift_d  = txShift_q;
    loadPend_d = 1'b0;
    skipFall_d = skipFall_q;

    if (riseEn) begin
      rxShift_d = rxByte;
      bitCnt_d  = bitCnt_q + 3'd1;
    end
    if (csRise || csFall) bitCnt_d = 3'd0;
    if (csFall) begin
      txShift_d  = 8'h00;
      skipFall_d = 1'b0;
    end

    // Reads prefetch the row of the byte the host will clock out next.
    if (byteDone) begin
      case (state_q)
        CMD: begin
          byteAddr_d = rxByte[BAW-1:0];
          if (!rxByte[7]) begin
            addr_d     = rowOf(rxByte[BAW-1:0]);
            loadPend_d = 1'b1;
          end
        end
        WDATA: begin
          we_d       = 1'b1;
          addr_d     = rowOf(byteAddr_q);
          wmask_d    = laneMaskOf(byteAddr_q);
          wdata_d    = {NB{rxByte}};
          byteAddr_d = byteAddr_q + BAW'(1);
        end
        RDATA: begin
          byteAddr_d = byteAddr_q + BAW'(1);
          addr_d     = rowOf(byteAddr_q + BAW'(1));
          loadPend_d = 1'b1;
        end
        default: ;
      endcase
    end

    if (loadPend_q) begin
      txShift_d  = laneByteOf(byteAddr_q, rdata_i);
      skipFall_d = 1'b1;
    end else if (sclkFall && state_q == RDATA) begin
      if (skipFall_q) skipFall_d = 1'b0;
      else            txShift_d  = {txShift_q[6:0], 1'b0};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rxShift_q  <= 8'h00;
      bitCnt_q   <= 3'd0;
      byteAddr_q <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      txShift_q  <= 8'h00;
      loadPend_q <= 1'b0;
      skipFall_q <= 1'b0;
    end else begin
      rxShift_q  <= rxShift_d;
      bitCnt_q   <= bitCnt_d;
      byteAddr_q <= byteAddr_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      wmask_q    <= wmask_d;
      txShift_q  <= txShift_d;
      loadPend_q <= loadPend_d;
      skipFall_q <= skipFall_d;
    end
  end

  assign addr_o  = addr_q;
  assign we_o    = we_q;
  assign wdata_o = wdata_q;
  assign wmask_o = wmask_q;

endmodule

// File: tb/tb_spi_rf_bridge.sv
// Bench for spi_rf_bridge: an SPI host model drives frames against a regfile model,
// with expected write beats and read bytes held in scoreboard queues.
`timescale 1ns/1ps
module tb_spi_rf_bridge;

  localparam int AW = 5;
  localparam int W  = 32;
  localparam int NB = 4;
  localparam int SS = 2;
  localparam logic [7:0] CHIP_ID = 8'hA5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sclk = 1'b0;
  logic          csN = 1'b1;
  logic          mosi = 1'b0;
  logic          miso, misoOe, we, frameActive;
  logic [AW-1:0] addr;
  logic [W-1:0]  wdata, rdata;
  logic [NB-1:0] wmask;

  always #5 clk = ~clk;

  spi_rf_bridge #(.AWIDTH(AW), .WIDTH(W), .SYNC_STAGES(SS)) dut (
    .clk_i(clk), .rst_i(rst), .spi_sclk_i(sclk), .spi_cs_n_i(csN), .spi_mosi_i(mosi),
    .spi_miso_o(miso), .spi_miso_oe_o(misoOe), .addr_o(addr), .we_o(we),
    .wdata_o(wdata), .wmask_o(wmask), .rdata_i(rdata), .frame_active_o(frameActive)
  );

  logic [W-1:0]  mem [0:31];
  logic [7:0]    refBytes [0:127];
  logic [7:0]    txData [0:7];
  logic [40:0]   wrQ[$];
  logic [7:0]    rdQ[$];
  int            vectors = 0;
  int            miscompares = 0;

  assign rdata = mem[addr];

  always @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < NB; i++) if (wmask[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every write strobe must match the oldest expected write beat.
  always @(negedge clk) begin
    logic [40:0] e;
    if (!rst && we) begin
      checkOutput("we_expected", 64'(wrQ.size() != 0), 64'd1);
      if (wrQ.size() != 0) begin
        e = wrQ.pop_front();
        checkOutput("write_beat", 64'({addr, wmask, wdata}), 64'(e));
      end
    end
  end

  task automatic alignPhase();
    int ph;
    ph = $urandom_range(1, 9);
    @(posedge clk);
    #(ph);
  endtask

  task automatic spiBits(input logic [7:0] tx, input int nb, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nb; i++) begin
      mosi = tx[7-i];
      #40;
      rx[7-i] = miso;
      sclk = 1'b1;
      #40;
      sclk = 1'b0;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] cmd, input int n);
    logic [7:0] rx, e;
    int a;
    a = int'(cmd[6:0]);
    if (!cmd[7]) for (int i = 0; i < n; i++) rdQ.push_back(refBytes[(a + i) % 128]);
    alignPhase();
    csN = 1'b0;
    #80;
    spiBits(cmd, 8, rx);
    checkOutput("cmd_miso", 64'(rx), 64'd0);
    checkOutput("frame_active", 64'({frameActive, misoOe}), 64'b11);
    for (int i = 0; i < n; i++) begin
      if (cmd[7]) begin
        wrQ.push_back({AW'(a >> 2), NB'(1 << (a % 4)), {NB{txData[i]}}});
        refBytes[a] = txData[i];
        spiBits(txData[i], 8, rx);
        checkOutput("write_miso", 64'(rx), 64'd0);
      end else begin
        spiBits(txData[i], 8, rx);
        e = rdQ.pop_front();
        checkOutput("read_byte", 64'(rx), 64'(e));
      end
      a = (a + 1) % 128;
    end
    #40;
    csN = 1'b1;
    mosi = 1'b0;
    #160;
    checkOutput("idle_pins", 64'({frameActive, misoOe, miso}), 64'd0);
  endtask

  initial begin
    logic [7:0] rx;
    for (int a = 0; a < 128; a++) refBytes[a] = 8'($urandom);
    refBytes[0]   = CHIP_ID;
    refBytes[126] = 8'h6E;
    refBytes[127] = 8'h7F;
    for (int r = 0; r < 32; r++)
      mem[r] = {refBytes[4*r+3], refBytes[4*r+2], refBytes[4*r+1], refBytes[4*r]};

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_miso_oe", 64'({miso, misoOe}), 64'd0);
    checkOutput("reset_addr", 64'(addr), 64'd0);
    checkOutput("reset_we_wmask", 64'({we, wmask}), 64'd0);
    checkOutput("reset_wdata", 64'(wdata), 64'd0);
    checkOutput("reset_frame", 64'(frameActive), 64'd0);
    rst = 1'b0;
    repeat (5) @(posedge clk);

    // Two-byte write at A=12: row 3, lanes 0 then 1.
    txData[0] = 8'h34; txData[1] = 8'h12;
    applyStimulus(8'h8C, 2);
    checkOutput("row3_lanes01", 64'(mem[3][15:0]), 64'h1234);

    // Chip ID read from byte address 0.
    txData[0] = 8'h00;
    applyStimulus(8'h00, 1);

    // Burst read across the address wrap 127 -> 0.
    txData[0] = 8'h00; txData[1] = 8'h00; txData[2] = 8'h00;
    applyStimulus(8'h7E, 3);
    checkOutput("wrap_addr", 64'(addr), 64'd0);

    // CS released after 5 data bits: no write, pins idle within SS+1 clocks.
    alignPhase();
    csN = 1'b0;
    #80;
    spiBits(8'hF0, 8, rx);
    spiBits(8'h5A, 5, rx);
    csN = 1'b1;
    repeat (SS + 1) @(posedge clk);
    #1;
    checkOutput("abort_pins", 64'({frameActive, misoOe, miso}), 64'd0);
    #200;
    txData[0] = 8'hAA;
    applyStimulus(8'h80, 1);

    // Reset in the middle of a data byte after one completed write.
    alignPhase();
    csN = 1'b0;
    #80;
    spiBits(8'h85, 8, rx);
    wrQ.push_back({AW'(1), NB'(4'b0010), {NB{8'h3C}}});
    refBytes[5] = 8'h3C;
    spiBits(8'h3C, 8, rx);
    spiBits(8'h77, 4, rx);
    #20;
    rst = 1'b1;
    #1;
    checkOutput("rst_addr", 64'(addr), 64'd0);
    checkOutput("rst_we_wmask", 64'({we, wmask}), 64'd0);
    checkOutput("rst_pins", 64'({frameActive, misoOe, miso}), 64'd0);
    #20;
    csN = 1'b1;
    mosi = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    txData[0] = 8'h00; txData[1] = 8'h00;
    applyStimulus(8'h05, 2);
    txData[0] = 8'hC3;
    applyStimulus(8'h86, 1);

    // Random frames against the byte-level reference.
    for (int f = 0; f < 200; f++) begin
      for (int i = 0; i < 2; i++) txData[i] = 8'($urandom);
      applyStimulus(8'($urandom), $urandom_range(0, 2));
    end

    repeat (20) @(posedge clk);
    @(negedge clk);
    checkOutput("wr_queue_drained", 64'(wrQ.size()), 64'd0);
    checkOutput("rd_queue_drained", 64'(rdQ.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
